// File: rtl/burst_line_adaptor_pkg.sv
// ============================================================================
// burst_line_adaptor_pkg : shared FSM encoding and address helper.  Rev 1.0
// ============================================================================
`default_nettype none

package burst_line_adaptor_pkg;

    localparam int MAX_ADDR_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_READ       = 3'd1,
        ST_READ_DONE  = 3'd2,
        ST_WRITE      = 3'd3,
        ST_WRITE_DONE = 3'd4
    } state_e;

    // Clears the byte-offset bits so the memory always sees a line-aligned address.
    function automatic logic [MAX_ADDR_W-1:0] align_addr(
        input logic [MAX_ADDR_W-1:0] addr,
        input int                    off_w
    );
        logic [MAX_ADDR_W-1:0] mask;
        mask = {MAX_ADDR_W{1'b1}} << off_w;
        return addr & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_beat_buffer.sv
// ============================================================================
// line_beat_buffer : BEATS x BURST_W line store with beat-wise access.  Rev 1.0
// ============================================================================
`default_nettype none

module line_beat_buffer #(
    parameter  int LINE_W  = 256,
    parameter  int BURST_W = 64,
    localparam int BEATS   = LINE_W / BURST_W,
    localparam int CNT_W   = $clog2(BEATS)
) (
    input  logic               clk,
    input  logic               load_i,
    input  logic [LINE_W-1:0]  line_i,
    input  logic               wr_en_i,
    input  logic [CNT_W-1:0]   beat_i,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [LINE_W-1:0]  line_o
);

    logic [BURST_W-1:0] buf_q [BEATS];

    // No reset: contents are only meaningful after a load or a full read.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BEATS; b++) begin
            if (load_i) begin
                buf_q[b] <= line_i[b*BURST_W +: BURST_W];
            end else if (wr_en_i && (beat_i == CNT_W'(b))) begin
                buf_q[b] <= burst_i;
            end
        end
    end

    for (genvar g = 0; g < BEATS; g++) begin : g_flat
        assign line_o[g*BURST_W +: BURST_W] = buf_q[g];
    end

    assign burst_o = buf_q[beat_i];

endmodule

`default_nettype wire

// File: rtl/burst_line_adaptor.sv
// ============================================================================
// burst_line_adaptor : splits an LLC line request into memory bursts.  Rev 1.0
// ============================================================================
`default_nettype none

module burst_line_adaptor
    import burst_line_adaptor_pkg::*;
#(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic [ADDR_W-1:0]  w_addr_aligned;
    logic               w_last_beat;
    logic               w_buf_load;
    logic               w_buf_we;
    logic [BURST_W-1:0] w_buf_burst;
    logic [LINE_W-1:0]  w_buf_line;

    assign w_addr_aligned = ADDR_W'(align_addr(MAX_ADDR_W'(address_i), OFF_W));
    assign w_last_beat    = (beat_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
        end
    end

    // The terminal beat leaves the counter at BEATS-1 so it never wraps.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (read_i || write_i) begin
                    state_d = read_i ? ST_READ : ST_WRITE;
                    addr_d  = w_addr_aligned;
                    beat_d  = '0;
                end
            end
            ST_READ: begin
                if (resp_i) begin
                    if (w_last_beat) state_d = ST_READ_DONE;
                    else             beat_d  = beat_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                if (resp_i) begin
                    if (w_last_beat) state_d = ST_WRITE_DONE;
                    else             beat_d  = beat_q + CNT_W'(1);
                end
            end
            ST_READ_DONE:  state_d = ST_IDLE;
            ST_WRITE_DONE: state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        read_o     = (state_q == ST_READ);
        write_o    = (state_q == ST_WRITE);
        resp_o     = (state_q == ST_READ_DONE) || (state_q == ST_WRITE_DONE);
        address_o  = (read_o || write_o) ? addr_q : '0;
        burst_o    = write_o ? w_buf_burst : '0;
        line_o     = (state_q == ST_READ_DONE) ? w_buf_line : '0;
        w_buf_load = (state_q == ST_IDLE) && !read_i && write_i;
        w_buf_we   = read_o && resp_i;
    end

    line_beat_buffer #(
        .LINE_W  (LINE_W),
        .BURST_W (BURST_W)
    ) u_buf (
        .clk     (clk),
        .load_i  (w_buf_load),
        .line_i  (line_i),
        .wr_en_i (w_buf_we),
        .beat_i  (beat_q),
        .burst_i (burst_i),
        .burst_o (w_buf_burst),
        .line_o  (w_buf_line)
    );

endmodule

`default_nettype wire

// File: tb/tb_burst_line_adaptor.sv
// ============================================================================
// tb_burst_line_adaptor : scoreboard bench over three adaptor geometries.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_burst_line_adaptor;

    typedef struct packed {
        logic         rd;
        logic [511:0] line;
    } exp_t;

    logic       clk    = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] done   = '0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    for (genvar I = 0; I < 3; I++) begin : g_inst
        localparam int LW = (I == 1) ? 512 : 256;
        localparam int BW = (I == 0) ? 64 : ((I == 1) ? 128 : 32);
        localparam int NB = LW / BW;

        logic          reset_n   = 1'b0;
        logic [LW-1:0] line_i    = '0;
        logic [LW-1:0] line_o;
        logic [31:0]   address_i = '0;
        logic [31:0]   address_o;
        logic          read_i    = 1'b0;
        logic          write_i   = 1'b0;
        logic          resp_o;
        logic [BW-1:0] burst_i   = '0;
        logic [BW-1:0] burst_o;
        logic          read_o;
        logic          write_o;
        logic          resp_i    = 1'b0;

        exp_t          expq[$];
        logic [BW-1:0] wbq[$];
        logic [BW-1:0] mem [logic [39:0]];
        logic [31:0]   exp_addr = '0;
        int            mode = 0;
        int            bidx = 0;
        int            acyc = 0;

        burst_line_adaptor #(
            .LINE_W  (LW),
            .BURST_W (BW),
            .ADDR_W  (32)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .line_i    (line_i),
            .line_o    (line_o),
            .address_i (address_i),
            .read_i    (read_i),
            .write_i   (write_i),
            .resp_o    (resp_o),
            .burst_i   (burst_i),
            .burst_o   (burst_o),
            .address_o (address_o),
            .read_o    (read_o),
            .write_o   (write_o),
            .resp_i    (resp_i)
        );

        // Burst memory model: mode 0 never stalls, 1 stalls randomly,
        // 2 stalls on the 2nd and 3rd active cycles.
        always @(posedge clk) begin
            logic [511:0] r;
            logic [39:0]  key;
            logic         go;
            #1;
            r = rnd512();
            if (read_o || write_o) begin
                case (mode)
                    0:       go = 1'b1;
                    1:       go = ($urandom_range(0, 3) != 0);
                    default: go = !(acyc == 1 || acyc == 2);
                endcase
                key = {address_o, 8'(bidx)};
                if (write_o && go) mem[key] = burst_o;
                if (read_o && go && mem.exists(key)) burst_i = mem[key];
                else                                 burst_i = r[BW-1:0];
                resp_i = go;
                if (go) bidx++;
                acyc++;
            end else begin
                resp_i  = r[BW];
                burst_i = r[BW-1:0];
                bidx    = 0;
                acyc    = 0;
            end
        end

        always @(negedge clk) begin
            exp_t e;
            if (reset_n) begin
                if (write_o) begin
                    if (wbq.size() == 0) begin
                        chk("write_o unexpected", write_o, 0);
                    end else begin
                        chk("burst_o", burst_o, wbq[0]);
                        if (resp_i) void'(wbq.pop_front());
                    end
                end else begin
                    chk("burst_o idle", burst_o, 0);
                end
                if (read_o || write_o) chk("address_o", address_o, exp_addr);
                else                   chk("address_o idle", address_o, 0);
                if (resp_o) begin
                    if (expq.size() == 0) begin
                        chk("resp_o unexpected", resp_o, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("line_o", line_o, e.rd ? e.line : 512'd0);
                    end
                end else begin
                    chk("line_o idle", line_o, 0);
                end
            end
        end

        task automatic check_outputs_zero();
            chk("rst read_o", read_o, 0);
            chk("rst write_o", write_o, 0);
            chk("rst resp_o", resp_o, 0);
            chk("rst burst_o", burst_o, 0);
            chk("rst line_o", line_o, 0);
            chk("rst address_o", address_o, 0);
        endtask

        task automatic do_reset();
            logic [511:0] r;
            r = rnd512();
            reset_n   = 1'b0;
            read_i    = 1'b0;
            write_i   = 1'b0;
            address_i = r[31:0];
            line_i    = r[LW-1:0];
            repeat (2) @(negedge clk);
            check_outputs_zero();
            reset_n = 1'b1;
        endtask

        task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] ea, input logic [LW-1:0] line,
                             input bit fill, output int nrd, output int nwr);
            int           cnt;
            logic [511:0] r;
            exp_t         e;
            exp_addr = ea;
            if (rd) begin
                if (fill) for (int b = 0; b < NB; b++) mem[{ea, 8'(b)}] = line[b*BW +: BW];
                e.rd   = 1'b1;
                e.line = 512'(line);
            end else begin
                for (int b = 0; b < NB; b++) wbq.push_back(line[b*BW +: BW]);
                e.rd   = 1'b0;
                e.line = '0;
            end
            expq.push_back(e);
            @(negedge clk);
            r         = rnd512();
            read_i    = rd;
            write_i   = wr;
            address_i = addr;
            line_i    = wr ? line : r[LW-1:0];
            @(negedge clk);
            r         = rnd512();
            read_i    = 1'b0;
            write_i   = 1'b0;
            address_i = r[63:32];
            line_i    = r[LW-1:0];
            cnt = 1;
            nrd = int'(read_o);
            nwr = int'(write_o);
            while (!resp_o && cnt < 400) begin
                @(negedge clk);
                cnt++;
                nrd += int'(read_o);
                nwr += int'(write_o);
            end
            if (!resp_o) begin
                chk("resp_o timeout", resp_o, 1);
            end else begin
                if (rd) chk("write_o during read", nwr, 0);
                else    chk("read_o during write", nrd, 0);
                if (mode == 0) begin
                    chk("latency to resp_o", cnt, NB + 1);
                    chk("active cycles", rd ? nrd : nwr, NB);
                end
            end
        endtask

        task automatic rand_op(input bit roundtrip);
            logic [511:0] r;
            logic [31:0]  a, ea;
            int           op, nr, nw;
            r    = rnd512();
            a    = $urandom();
            ea   = (a / (LW / 8)) * (LW / 8);
            mode = $urandom_range(0, 1);
            if (roundtrip) begin
                issue(1'b0, 1'b1, a, ea, r[LW-1:0], 1'b0, nr, nw);
                mode = $urandom_range(0, 1);
                issue(1'b1, 1'b0, ea + 32'($urandom_range(0, LW / 8 - 1)), ea,
                      r[LW-1:0], 1'b0, nr, nw);
            end else begin
                op = $urandom_range(0, 2);
                if (op == 1) issue(1'b0, 1'b1, a, ea, r[LW-1:0], 1'b1, nr, nw);
                else         issue(1'b1, op == 2, a, ea, r[LW-1:0], 1'b1, nr, nw);
            end
        endtask

        if (I == 0) begin : g_seq_default
            initial begin
                logic [LW-1:0] l;
                logic [511:0]  r;
                logic [31:0]   a, ea;
                int            nr, nw;
                do_reset();
                mode = 0;
                for (int b = 0; b < NB; b++) l[b*BW +: BW] = {16{4'(b + 1)}};
                issue(1'b1, 1'b0, 32'h0000_0064, 32'h0000_0060, l, 1'b1, nr, nw);
                mode = 2;
                for (int b = 0; b < NB; b++) l[b*BW +: BW] = {16{4'(10 + b)}};
                issue(1'b0, 1'b1, 32'h0000_1234, 32'h0000_1220, l, 1'b0, nr, nw);
                chk("write_o cycles with two stalls", nw, NB + 2);
                mode = 0;
                r = rnd512();
                issue(1'b1, 1'b1, 32'h0000_0ABC, 32'h0000_0AA0, r[LW-1:0], 1'b1, nr, nw);
                // Reset while the third beat of a read is outstanding.
                r  = rnd512();
                a  = $urandom();
                ea = (a / (LW / 8)) * (LW / 8);
                for (int b = 0; b < NB; b++) mem[{ea, 8'(b)}] = r[b*BW +: BW];
                exp_addr = ea;
                @(negedge clk);
                read_i    = 1'b1;
                address_i = a;
                @(negedge clk);
                read_i = 1'b0;
                repeat (2) @(negedge clk);
                #2 reset_n = 1'b0;
                #1 check_outputs_zero();
                repeat (2) @(negedge clk);
                reset_n = 1'b1;
                r = rnd512();
                issue(1'b1, 1'b0, a, ea, r[LW-1:0], 1'b1, nr, nw);
                for (int k = 0; k < 14; k++) rand_op(1'b0);
                repeat (3) @(negedge clk);
                done[I] = 1'b1;
            end
        end else if (I == 1) begin : g_seq_wide
            initial begin
                logic [511:0] r;
                int           nr, nw;
                do_reset();
                mode = 0;
                r = rnd512();
                issue(1'b1, 1'b0, 32'h1234_5678, 32'h1234_5640, r[LW-1:0], 1'b1, nr, nw);
                for (int k = 0; k < 8; k++) rand_op(1'b0);
                repeat (3) @(negedge clk);
                done[I] = 1'b1;
            end
        end else begin : g_seq_narrow
            initial begin
                do_reset();
                for (int k = 0; k < 6; k++) rand_op(1'b1);
                repeat (3) @(negedge clk);
                done[I] = 1'b1;
            end
        end
    end

    initial begin
        int c;
        c = 0;
        while (done != 3'b111 && c < 50000) begin
            @(negedge clk);
            c++;
        end
        if (done != 3'b111) chk("global timeout", done, 3'b111);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
